frame_buffer: RTL and testbench

- Single-clock simple dual-port pixel memory holding one 320x240 frame of RGB332 pixels (76 800 bytes).
- Port A is write-only and is driven by the rasteriser/drawing engine.
- Port B is read-only and is driven by the VGA scan-out path. That path forms its address as y*320+x and 2x-upscales to 640x480.
- Inferred as block RAM; only the read-data register is affected by reset.

---
 rtl/fb_pkg.sv | 29 ++
 rtl/fb_sdp_ram.sv | 32 +++
 rtl/frame_buffer.sv | 76 +++++++
 tb/tb_frame_buffer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: frame geometry, pixel type and addressing helpers
// shared by the frame buffer and its users.
package fb_pkg;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
  localparam int FB_ADDR_W = 17;

  typedef logic [7:0] pixel_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  function automatic pixel_t rgb332(
    input logic [7:0] r8,
    input logic [7:0] g8,
    input logic [7:0] b8
  );
    return {r8[7:5], g8[7:5], b8[7:6]};
  endfunction

  function automatic fb_addr_t fb_addr(
    input logic [8:0] x,
    input logic [7:0] y
  );
    return fb_addr_t'(y) * fb_addr_t'(FB_WIDTH)
         + fb_addr_t'(x);
  endfunction

endpackage

// File: rtl/fb_sdp_ram.sv
// fb_sdp_ram: generic simple dual-port RAM, one write port and
// one registered read port; the array itself is never reset.
module fb_sdp_ram #(
  parameter int DW    = 8,
  parameter int AW    = 17,
  parameter int DEPTH = 76800
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read-first: the read samples the array before this edge's write.
  always_ff @(posedge clk) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer.sv
// frame_buffer: 320x240 RGB332 pixel store, write port for the
// drawing engine, read port for scan-out, black outside the frame.
module frame_buffer #(
  parameter int FB_WIDTH   = fb_pkg::FB_WIDTH,
  parameter int FB_HEIGHT  = fb_pkg::FB_HEIGHT,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = fb_pkg::FB_ADDR_W,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] doutb
);

  localparam int DEPTH = FB_WIDTH * FB_HEIGHT;
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

  logic              wr_en;
  logic              vld_d;
  logic              vld_q;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] pix;

  assign wr_en = wea & arstn & (addra < LIMIT);
  assign vld_d = addrb < LIMIT;

  fb_sdp_ram #(
    .DW    (DATA_W),
    .AW    (ADDR_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (addra),
    .wdata_i (dina),
    .raddr_i (addrb),
    .rdata_o (ram_q)
  );

  // Tracks the read in flight; reset kills it and forces black.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign pix = vld_q ? ram_q : '0;

  generate
    if (RD_LATENCY >= 2) begin : g_pipe
      logic [DATA_W-1:0] dout_q;
      logic [DATA_W-1:0] dout_d;

      assign dout_d = pix;

      always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
          dout_q <= '0;
        end else begin
          dout_q <= dout_d;
        end
      end

      assign doutb = dout_q;
    end else begin : g_direct
      assign doutb = pix;
    end
  endgenerate

endmodule

// File: tb/tb_frame_buffer.sv
// tb_frame_buffer: directed vectors and scoreboarded raster
// passes for the frame buffer.
module tb_frame_buffer;
  import fb_pkg::*;

  localparam int LAT = 1;
  localparam int W   = 320;
  localparam int DEP = 76800;

  logic        clk;
  logic        arstn;
  logic        wea;
  logic [16:0] addra;
  logic [7:0]  dina;
  logic [16:0] addrb;
  logic [7:0]  doutb;

  int total;
  int bad;

  logic [7:0] eq[$];
  logic       cq[$];
  string      nq[$];

  typedef struct {
    logic       we;
    int         aa;
    logic [7:0] di;
    int         ab;
    logic [7:0] e;
    string      nm;
  } vec_t;

  vec_t tv[15];

  frame_buffer #(
    .RD_LATENCY (LAT)
  ) dut (
    .clk   (clk),
    .arstn (arstn),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .addrb (addrb),
    .doutb (doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] grad(input int a);
    int x;
    int y;
    int s;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    x = a % W;
    y = a / W;
    s = x + y;
    r = x[7:0];
    g = y[7:0];
    b = s[7:0];
    return {r[7:5], g[7:5], b[7:6]};
  endfunction

  function automatic logic [7:0] tile(input int x, input int y);
    int t;
    t = (x - 10) / 10 + (y - 160) / 10;
    return (t % 2 == 0) ? 8'hFF : 8'h00;
  endfunction

  task automatic chk8(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: doutb=%02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic chkn(input string nm, input int act,
                      input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic we, input int aa,
                     input logic [7:0] di, input int ab,
                     input logic ck, input logic [7:0] e,
                     input string nm);
    logic [7:0] e0;
    logic       c0;
    string      n0;
    wea   = we;
    addra = aa[16:0];
    dina  = di;
    addrb = ab[16:0];
    eq.push_back(e);
    cq.push_back(ck);
    nq.push_back(nm);
    step();
    if (eq.size() == LAT) begin
      e0 = eq.pop_front();
      c0 = cq.pop_front();
      n0 = nq.pop_front();
      if (c0) chk8(n0, doutb, e0);
    end
  endtask

  task automatic flush();
    repeat (LAT - 1) cyc(1'b0, 0, 8'h00, 0, 1'b0, 8'h00, "idle");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    arstn = 1'b0;
    wea   = 1'b0;
    addra = '0;
    dina  = '0;
    addrb = '0;

    #12;
    chk8("rst_init", doutb, 8'h00);
    step();
    arstn = 1'b1;

    chkn("pkg_fb_addr", int'(fb_addr(9'd10, 8'd10)), 3210);
    chkn("pkg_rgb332", int'(rgb332(8'hFF, 8'h20, 8'hC0)), 8'hE7);

    // Gradient fill, each address read back one cycle after its write.
    for (int a = 0; a < DEP; a++) begin
      cyc(1'b1, a, grad(a), (a == 0) ? 0 : a - 1, a != 0,
          grad((a == 0) ? 0 : a - 1),
          (a == 1) ? "grad_addr0" : "grad");
    end
    cyc(1'b0, 0, 8'h00, DEP - 1, 1'b1, grad(DEP - 1),
        "grad_addr76799");
    flush();

    tv[0]  = '{1'b1, 3210,   8'hE0, 3210,   8'h00, "rdw3210_old"};
    tv[1]  = '{1'b0, 0,      8'h00, 3210,   8'hE0, "rd3210_new"};
    tv[2]  = '{1'b1, 76800,  8'hFF, 0,      8'h00, "oor_w_a0"};
    tv[3]  = '{1'b1, 131071, 8'hFF, 76800,  8'h00, "oor_rd76800"};
    tv[4]  = '{1'b0, 0,      8'h00, 131071, 8'h00, "oor_rd131071"};
    tv[5]  = '{1'b0, 0,      8'h00, 0,      8'h00, "alias_a0"};
    tv[6]  = '{1'b0, 0,      8'h00, 11264,  8'h45, "alias_11264"};
    tv[7]  = '{1'b0, 0,      8'h00, 65535,  8'hFB, "alias_65535"};
    tv[8]  = '{1'b0, 0,      8'h00, 76799,  8'h3C, "last_addr"};
    tv[9]  = '{1'b1, 500,    8'h03, 0,      8'h00, "w500_a0"};
    tv[10] = '{1'b1, 500,    8'h1C, 500,    8'h03, "rdw500_old"};
    tv[11] = '{1'b0, 0,      8'h00, 500,    8'h1C, "rd500_new"};
    tv[12] = '{1'b1, 600,    8'hAA, 11264,  8'h45, "b2b_rd11264"};
    tv[13] = '{1'b1, 601,    8'h55, 600,    8'hAA, "b2b_rd600"};
    tv[14] = '{1'b0, 0,      8'h00, 601,    8'h55, "b2b_rd601"};

    for (int i = 0; i < 15; i++) begin
      cyc(tv[i].we, tv[i].aa, tv[i].di, tv[i].ab, 1'b1,
          tv[i].e, tv[i].nm);
    end
    flush();

    // Asynchronous reset in the middle of a cycle.
    cyc(1'b1, 100, 8'hFF, 0, 1'b0, 8'h00, "w100");
    flush();
    wea   = 1'b0;
    addrb = 17'd100;
    repeat (LAT) step();
    chk8("pre_rst_100", doutb, 8'hFF);
    #2;
    arstn = 1'b0;
    #1;
    chk8("rst_async", doutb, 8'h00);
    wea   = 1'b1;
    addra = 17'd101;
    dina  = 8'h77;
    repeat (2) step();
    chk8("rst_hold", doutb, 8'h00);
    wea   = 1'b0;
    arstn = 1'b1;
    addrb = 17'd101;
    repeat (LAT) step();
    chk8("rst_w101_blocked", doutb, 8'h61);
    addrb = 17'd100;
    repeat (LAT) step();
    chk8("rst_keep_100", doutb, 8'hFF);

    // Checkerboard writes with the row above read back concurrently.
    for (int y = 160; y <= 230; y++) begin
      for (int x = 10; x < 150; x++) begin
        cyc(y <= 229, y * W + x, tile(x, y), (y - 1) * W + x,
            1'b1,
            (y == 160) ? grad((y - 1) * W + x) : tile(x, y - 1),
            "checker");
      end
    end
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
